// File: rtl/ex_md_unit_pkg.sv
// Shared encodings for the execute stage: opcode classes, funct3 codes,
// funct7 select bits, multiply/divide iterator states and operand-sign helpers.
package ex_md_unit_pkg;

    localparam int ALU_OP_W   = 7;
    localparam int REG_ADDR_W = 5;

    localparam logic [ALU_OP_W-1:0] EXE_I_TYPE_OP = 7'b0010011;
    localparam logic [ALU_OP_W-1:0] EXE_R_TYPE_OP = 7'b0110011;

    // funct7_i packs {funct7[5], funct7[0]}
    localparam int F7_ALT_BIT = 1;
    localparam int F7_M_BIT   = 0;

    // Base integer funct3 codes
    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    // M-extension funct3 codes
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } mdState_t;

    // rs1 is treated as two's complement for these M ops
    function automatic logic mdOpASigned(input logic [2:0] funct3);
        return (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    endfunction

    // rs2 is treated as two's complement for these M ops
    function automatic logic mdOpBSigned(input logic [2:0] funct3);
        return (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_md_unit_iter.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step
// per cycle on operand magnitudes, with the sign fixed up in the DONE state.
module ex_md_iter
    import ex_md_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_kill,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_opA,
    input  logic [XLEN-1:0] i_opB,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdState_t        r_state;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_opB;
    logic [2:0]      r_funct3;
    logic            r_negA;
    logic            r_negB;
    logic            r_divZero;
    logic            r_overflow;

    logic            w_negA;
    logic            w_negB;
    logic [XLEN-1:0] w_magA;
    logic [XLEN-1:0] w_magB;
    logic            w_divZero;
    logic            w_overflow;
    logic [XLEN:0]   w_mulSum;
    logic [XLEN:0]   w_divShift;
    logic [XLEN:0]   w_divDiff;
    logic [2*XLEN-1:0] w_prodFix;
    logic [XLEN-1:0] w_quoFix;
    logic [XLEN-1:0] w_remFix;

    // Operand magnitudes, division corner flags and the per-step datapath
    always_comb begin
        w_negA     = mdOpASigned(i_funct3) & i_opA[XLEN-1];
        w_negB     = mdOpBSigned(i_funct3) & i_opB[XLEN-1];
        w_magA     = w_negA ? -i_opA : i_opA;
        w_magB     = w_negB ? -i_opB : i_opB;
        w_divZero  = i_funct3[2] & (i_opB == '0);
        w_overflow = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                     (i_opA == MIN_NEG) && (i_opB == '1);
        w_mulSum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opB} : '0);
        w_divShift = {r_hi, r_lo[XLEN-1]};
        w_divDiff  = w_divShift - {1'b0, r_opB};
    end

    // Control FSM and iteration registers; rst and kill both drop to IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= MD_IDLE;
            r_count    <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_opB      <= '0;
            r_funct3   <= '0;
            r_negA     <= 1'b0;
            r_negB     <= 1'b0;
            r_divZero  <= 1'b0;
            r_overflow <= 1'b0;
        end else if (i_kill) begin
            r_state <= MD_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (i_start) begin
                        r_state    <= MD_RUN;
                        r_count    <= '0;
                        r_hi       <= '0;
                        r_lo       <= w_magA;
                        r_opB      <= w_magB;
                        r_funct3   <= i_funct3;
                        r_negA     <= w_negA;
                        r_negB     <= w_negB;
                        r_divZero  <= w_divZero;
                        r_overflow <= w_overflow;
                    end
                end
                MD_RUN: begin
                    if (r_funct3[2]) begin
                        if (!w_divDiff[XLEN]) begin
                            r_hi <= w_divDiff[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b1};
                        end else begin
                            r_hi <= w_divShift[XLEN-1:0];
                            r_lo <= {r_lo[XLEN-2:0], 1'b0};
                        end
                    end else begin
                        r_hi <= w_mulSum[XLEN:1];
                        r_lo <= {w_mulSum[0], r_lo[XLEN-1:1]};
                    end
                    r_count <= r_count + CW'(1);
                    if (r_count == CW'(XLEN - 1)) begin
                        r_state <= MD_DONE;
                    end
                end
                MD_DONE: begin
                    r_state <= MD_IDLE;
                end
                default: begin
                    r_state <= MD_IDLE;
                end
            endcase
        end
    end

    // Sign fix-up and result selection, valid while in DONE
    always_comb begin
        w_prodFix = (r_negA ^ r_negB) ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_quoFix  = (r_negA ^ r_negB) ? -r_lo : r_lo;
        w_remFix  = r_negA ? -r_hi : r_hi;
        case (r_funct3)
            F3_MUL:                        o_result = w_prodFix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  o_result = w_prodFix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU: begin
                if (r_overflow)     o_result = MIN_NEG;
                else if (r_divZero) o_result = '1;
                else                o_result = w_quoFix;
            end
            default: begin
                if (r_overflow) o_result = '0;
                else            o_result = w_remFix;
            end
        endcase
        o_busy = (r_state != MD_IDLE);
        o_done = (r_state == MD_DONE);
    end

endmodule

// File: rtl/ex_md_unit.sv
// Execute stage: single-cycle RV32I ALU plus optional iterative M-extension
// unit. All results are registered; ready_o drops while an M op iterates.
module ex_md_unit
    import ex_md_unit_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit MD_ENABLE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  stallreq_o,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [2:0]            alufunct3_i,
    input  logic [1:0]            funct7_i,
    input  logic [XLEN-1:0]       reg1_i,
    input  logic [XLEN-1:0]       reg2_i,
    input  logic [REG_ADDR_W-1:0] wreg_i,
    input  logic                  wd_i,
    output logic                  valid_o,
    output logic [REG_ADDR_W-1:0] wreg_o,
    output logic                  wd_o,
    output logic [XLEN-1:0]       wdata_o
);

    localparam int SHW = $clog2(XLEN);

    logic                  r_pendWd;
    logic [REG_ADDR_W-1:0] r_pendWreg;

    logic            w_isI;
    logic            w_isR;
    logic            w_alt;
    logic            w_mExt;
    logic            w_legal;
    logic            w_isMd;
    logic            w_writeOk;
    logic            w_accept;
    logic [SHW-1:0]  w_shamt;
    logic [XLEN-1:0] w_aluResult;
    logic            w_mdBusy;
    logic            w_mdDone;
    logic [XLEN-1:0] w_mdResult;

    // Decode legality, route M ops to the iterator, and compute the ALU result
    always_comb begin
        w_isI     = (aluop_i == EXE_I_TYPE_OP);
        w_isR     = (aluop_i == EXE_R_TYPE_OP);
        w_alt     = funct7_i[F7_ALT_BIT];
        w_mExt    = funct7_i[F7_M_BIT];
        w_shamt   = reg2_i[SHW-1:0];
        w_legal   = 1'b0;
        w_isMd    = 1'b0;
        if (w_isI) begin
            case (alufunct3_i)
                F3_SLL:  w_legal = (funct7_i == 2'b00);
                F3_SR:   w_legal = ~w_mExt;
                default: w_legal = 1'b1;
            endcase
        end else if (w_isR) begin
            if (w_mExt) begin
                w_legal = ~w_alt & MD_ENABLE;
                w_isMd  = ~w_alt & MD_ENABLE;
            end else begin
                w_legal = ~w_alt | (alufunct3_i == F3_ADD) | (alufunct3_i == F3_SR);
            end
        end

        case (alufunct3_i)
            F3_ADD:  w_aluResult = (w_isR & w_alt) ? reg1_i - reg2_i : reg1_i + reg2_i;
            F3_SLL:  w_aluResult = reg1_i << w_shamt;
            F3_SLT:  w_aluResult = {{(XLEN-1){1'b0}}, $signed(reg1_i) < $signed(reg2_i)};
            F3_SLTU: w_aluResult = {{(XLEN-1){1'b0}}, reg1_i < reg2_i};
            F3_XOR:  w_aluResult = reg1_i ^ reg2_i;
            F3_SR:   w_aluResult = w_alt ? $unsigned($signed(reg1_i) >>> w_shamt)
                                         : reg1_i >> w_shamt;
            F3_OR:   w_aluResult = reg1_i | reg2_i;
            default: w_aluResult = reg1_i & reg2_i;
        endcase

        w_writeOk  = wd_i & (wreg_i != '0);
        ready_o    = ~w_mdBusy;
        stallreq_o = w_mdBusy;
        w_accept   = valid_i & ready_o & ~flush_i;
    end

    ex_md_iter #(
        .XLEN(XLEN)
    ) u_iter (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_accept & w_isMd),
        .i_kill   (flush_i),
        .i_funct3 (alufunct3_i),
        .i_opA    (reg1_i),
        .i_opB    (reg2_i),
        .o_busy   (w_mdBusy),
        .o_done   (w_mdDone),
        .o_result (w_mdResult)
    );

    // Output registers: flush beats completion, completion beats a new accept
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_o    <= 1'b0;
            wd_o       <= 1'b0;
            wreg_o     <= '0;
            wdata_o    <= '0;
            r_pendWreg <= '0;
            r_pendWd   <= 1'b0;
        end else if (flush_i) begin
            valid_o <= 1'b0;
            wd_o    <= 1'b0;
        end else if (w_mdDone) begin
            valid_o <= 1'b1;
            wreg_o  <= r_pendWreg;
            wd_o    <= r_pendWd;
            wdata_o <= w_mdResult;
        end else if (w_accept && w_isMd) begin
            valid_o    <= 1'b0;
            wd_o       <= 1'b0;
            r_pendWreg <= wreg_i;
            r_pendWd   <= w_writeOk;
        end else if (w_accept) begin
            valid_o <= 1'b1;
            wreg_o  <= wreg_i;
            wd_o    <= w_legal & w_writeOk;
            wdata_o <= w_legal ? w_aluResult : '0;
        end else begin
            valid_o <= 1'b0;
            wd_o    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ex_md_unit.sv
// Self-checking bench for ex_md_unit: directed corner vectors plus randomized
// ops checked against an arithmetic reference model.
module tb_ex_md_unit;
    import ex_md_unit_pkg::*;

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPR = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst, flush_i, valid_i, wd_i;
    logic [6:0]  aluop_i;
    logic [2:0]  alufunct3_i;
    logic [1:0]  funct7_i;
    logic [31:0] reg1_i, reg2_i;
    logic [4:0]  wreg_i;

    logic        ready_o, stallreq_o, valid_o, wd_o;
    logic [4:0]  wreg_o;
    logic [31:0] wdata_o;

    logic        d0Ready, d0Stall, d0Valid, d0Wd;
    logic [4:0]  d0Wreg;
    logic [31:0] d0Wdata;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [1:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wr;
        logic        wd;
        logic [31:0] expData;
        logic        expWd;
        int          expLat;
    } vec_t;

    ex_md_unit #(.XLEN(32), .MD_ENABLE(1'b1)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(ready_o), .stallreq_o(stallreq_o), .aluop_i(aluop_i),
        .alufunct3_i(alufunct3_i), .funct7_i(funct7_i), .reg1_i(reg1_i),
        .reg2_i(reg2_i), .wreg_i(wreg_i), .wd_i(wd_i), .valid_o(valid_o),
        .wreg_o(wreg_o), .wd_o(wd_o), .wdata_o(wdata_o)
    );

    ex_md_unit #(.XLEN(32), .MD_ENABLE(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i),
        .ready_o(d0Ready), .stallreq_o(d0Stall), .aluop_i(aluop_i),
        .alufunct3_i(alufunct3_i), .funct7_i(funct7_i), .reg1_i(reg1_i),
        .reg2_i(reg2_i), .wreg_i(wreg_i), .wd_i(wd_i), .valid_o(d0Valid),
        .wreg_o(d0Wreg), .wd_o(d0Wd), .wdata_o(d0Wdata)
    );

    always #5 clk = ~clk;

    // Hard stop if something wedges beyond every per-wait bound
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=running req=finished");
        $fatal(1, "[TB] global timeout");
    end

    // Whether the op is executed (vs completing as illegal)
    function automatic bit refLegal(input logic [6:0] op, input logic [2:0] f3,
                                    input logic [1:0] f7, input bit mdOn);
        if (op == OPI) begin
            if (f3 == 3'd1) return f7 == 2'b00;
            if (f3 == 3'd5) return f7[0] == 1'b0;
            return 1'b1;
        end
        if (op == OPR) begin
            if (f7[0]) return mdOn && !f7[1];
            return !f7[1] || f3 == 3'd0 || f3 == 3'd5;
        end
        return 1'b0;
    endfunction

    // Architectural result of a legal op, computed with plain integer arithmetic
    function automatic logic [31:0] refValue(input logic [6:0] op, input logic [2:0] f3,
                                             input logic [1:0] f7, input logic [31:0] a,
                                             input logic [31:0] b);
        int          sa = a;
        int          sb = b;
        logic [4:0]  sh = b[4:0];
        logic [63:0] p;
        bit          ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (op == OPR && f7[0]) begin
            case (f3)
                3'd0: return a * b;
                3'd1: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; return p[63:32]; end
                3'd2: begin p = {{32{a[31]}}, a} * {32'd0, b};       return p[63:32]; end
                3'd3: begin p = {32'd0, a} * {32'd0, b};             return p[63:32]; end
                3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
                3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
                3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
                default: return (b == 0) ? a : a % b;
            endcase
        end
        case (f3)
            3'd0: return (op == OPR && f7[1]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return (sa < sb) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7[1] ? 32'(sa >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    // Offer one op when the unit is ready and collect the registered result
    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                                 input logic [1:0] f7, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] wr,
                                 input logic wdIn, output logic [31:0] gotData,
                                 output logic gotWd, output logic [4:0] gotWreg,
                                 output int lat, output int lowCycles);
        int guard = 0;
        while (!ready_o && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        aluop_i = op; alufunct3_i = f3; funct7_i = f7;
        reg1_i = a; reg2_i = b; wreg_i = wr; wd_i = wdIn;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        lat = 0;
        lowCycles = 0;
        while (!valid_o && lat < 100) begin
            if (!ready_o) lowCycles++;
            @(posedge clk); #1;
            lat++;
        end
        gotData = wdata_o;
        gotWd   = wd_o;
        gotWreg = wreg_o;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush_i = 1'b0; valid_i = 1'b0; wd_i = 1'b0;
        aluop_i = '0; alufunct3_i = '0; funct7_i = '0;
        reg1_i = '0; reg2_i = '0; wreg_i = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b req=0", valid_o); end
        total++; if (wd_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_wd got=%b req=0", wd_o); end
        total++; if (wreg_o !== 5'd0 || wdata_o !== 32'd0) begin bad++; $display("[TB] FAIL reset_data got=%h/%h req=0/0", wreg_o, wdata_o); end
        total++; if (ready_o !== 1'b1 || stallreq_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ready got=%b/%b req=1/0", ready_o, stallreq_o); end
        rst = 1'b0;
    endtask

    task automatic runVectors(input vec_t v[]);
        logic [31:0] d; logic w; logic [4:0] r; int lat, low;
        foreach (v[i]) begin
            applyStimulus(v[i].op, v[i].f3, v[i].f7, v[i].a, v[i].b, v[i].wr, v[i].wd, d, w, r, lat, low);
            total++; if (d !== v[i].expData) begin bad++; $display("[TB] FAIL %s data got=%h req=%h", v[i].name, d, v[i].expData); end
            total++; if (w !== v[i].expWd) begin bad++; $display("[TB] FAIL %s wd got=%b req=%b", v[i].name, w, v[i].expWd); end
            total++; if (lat !== v[i].expLat || low !== v[i].expLat) begin bad++; $display("[TB] FAIL %s timing got=%0d/%0d req=%0d", v[i].name, lat, low, v[i].expLat); end
            total++; if (r !== v[i].wr) begin bad++; $display("[TB] FAIL %s wreg got=%0d req=%0d", v[i].name, r, v[i].wr); end
        end
    endtask

    task automatic test_alu();
        vec_t v[] = '{
            '{"addi",    OPI, 3'd0, 2'b00, 32'd5,        32'hFFFF_FFFD, 5'd3, 1'b1, 32'd2,         1'b1, 0},
            '{"sub",     OPR, 3'd0, 2'b10, 32'd3,        32'd5,         5'd4, 1'b1, 32'hFFFF_FFFE, 1'b1, 0},
            '{"sra",     OPR, 3'd5, 2'b10, 32'h8000_0000, 32'd4,        5'd5, 1'b1, 32'hF800_0000, 1'b1, 0},
            '{"sltu",    OPR, 3'd3, 2'b00, 32'd1,        32'hFFFF_FFFF, 5'd6, 1'b1, 32'd1,         1'b1, 0},
            '{"x0",      OPI, 3'd0, 2'b00, 32'd9,        32'd1,         5'd0, 1'b1, 32'd10,        1'b0, 0},
            '{"ill_sll", OPR, 3'd1, 2'b10, 32'd9,        32'd1,         5'd7, 1'b1, 32'd0,         1'b0, 0},
            '{"ill_op",  7'h7F, 3'd0, 2'b00, 32'd9,      32'd1,         5'd8, 1'b1, 32'd0,         1'b0, 0}
        };
        runVectors(v);
    endtask

    task automatic test_mul();
        vec_t v[] = '{
            '{"mulhu", OPR, 3'd3, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9,  1'b1, 32'hFFFF_FFFE, 1'b1, 33},
            '{"mul",   OPR, 3'd0, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 1'b1, 32'h0000_0001, 1'b1, 33},
            '{"mulh",  OPR, 3'd1, 2'b01, 32'hFFFF_FFF9, 32'd3,         5'd11, 1'b1, 32'hFFFF_FFFF, 1'b1, 33}
        };
        runVectors(v);
        @(posedge clk); #1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL mul_pulse got=%b req=0", valid_o); end
    endtask

    task automatic test_div();
        vec_t v[] = '{
            '{"div_by0",  OPR, 3'd4, 2'b01, 32'd7,         32'd0,         5'd12, 1'b1, 32'hFFFF_FFFF, 1'b1, 33},
            '{"remu_by0", OPR, 3'd7, 2'b01, 32'd7,         32'd0,         5'd13, 1'b1, 32'd7,         1'b1, 33},
            '{"div_ovf",  OPR, 3'd4, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 1'b1, 32'h8000_0000, 1'b1, 33},
            '{"rem_ovf",  OPR, 3'd6, 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 1'b1, 32'd0,         1'b1, 33},
            '{"div_neg",  OPR, 3'd4, 2'b01, 32'hFFFF_FFF9, 32'd2,         5'd16, 1'b1, 32'hFFFF_FFFD, 1'b1, 33}
        };
        runVectors(v);
    endtask

    task automatic test_back_to_back();
        logic [31:0] expd[8];
        int guard = 0;
        while (!ready_o && guard < 100) begin @(posedge clk); #1; guard++; end
        aluop_i = OPI; alufunct3_i = 3'd0; funct7_i = 2'b00; wreg_i = 5'd2; wd_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            reg1_i = $urandom; reg2_i = $urandom;
            expd[i] = reg1_i + reg2_i;
            valid_i = 1'b1;
            @(posedge clk); #1;
            total++; if (valid_o !== 1'b1 || wdata_o !== expd[i]) begin bad++; $display("[TB] FAIL b2b_%0d got=%b/%h req=1/%h", i, valid_o, wdata_o, expd[i]); end
        end
        valid_i = 1'b0;
    endtask

    task automatic test_random();
        logic [6:0] op; logic [2:0] f3; logic [1:0] f7; logic [31:0] a, b;
        logic [4:0] wr; logic wdIn; logic [31:0] d; logic w; logic [4:0] r;
        logic [31:0] expd; logic expw; int lat, low, expLat, kind;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            f3 = 3'($urandom_range(0, 7));
            a = $urandom; b = $urandom;
            wr = 5'($urandom_range(0, 31)); wdIn = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                op = OPI;
                f7 = (f3 == 3'd5) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            end else if (kind == 1) begin
                op = OPR;
                f7 = (f3 == 3'd0 || f3 == 3'd5) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            end else begin
                op = OPR; f7 = 2'b01;
                case ($urandom_range(0, 3))
                    0: b = 32'd0;
                    1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                    2: b = $urandom_range(1, 20);
                    default: ;
                endcase
            end
            expd   = refLegal(op, f3, f7, 1'b1) ? refValue(op, f3, f7, a, b) : 32'd0;
            expw   = refLegal(op, f3, f7, 1'b1) && wdIn && (wr != 0);
            expLat = (kind == 2) ? 33 : 0;
            applyStimulus(op, f3, f7, a, b, wr, wdIn, d, w, r, lat, low);
            total++; if (d !== expd || w !== expw || r !== wr) begin bad++; $display("[TB] FAIL rand_%0d op=%h f3=%0d f7=%b a=%h b=%h got=%h/%b/%0d req=%h/%b/%0d", i, op, f3, f7, a, b, d, w, r, expd, expw, wr); end
            total++; if (lat !== expLat) begin bad++; $display("[TB] FAIL rand_lat_%0d got=%0d req=%0d", i, lat, expLat); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] d; logic w; logic [4:0] r; int lat, low;
        bit sawValid = 1'b0;
        int guard = 0;
        while (!ready_o && guard < 100) begin @(posedge clk); #1; guard++; end
        aluop_i = OPR; alufunct3_i = 3'd5; funct7_i = 2'b01;
        reg1_i = 32'd100; reg2_i = 32'd7; wreg_i = 5'd3; wd_i = 1'b1;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        total++; if (ready_o !== 1'b1 || valid_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_state got=%b/%b req=1/0", ready_o, valid_o); end
        repeat (40) begin
            @(posedge clk); #1;
            if (valid_o) sawValid = 1'b1;
        end
        total++; if (sawValid !== 1'b0) begin bad++; $display("[TB] FAIL flush_noresult got=%b req=0", sawValid); end
        applyStimulus(OPI, 3'd0, 2'b00, 32'd1, 32'd1, 5'd4, 1'b1, d, w, r, lat, low);
        total++; if (d !== 32'd2 || lat !== 0) begin bad++; $display("[TB] FAIL flush_addi got=%h/%0d req=2/0", d, lat); end
        aluop_i = OPI; alufunct3_i = 3'd0; reg1_i = 32'd5; reg2_i = 32'd5;
        valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_offered got=%b req=0", valid_o); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] d; logic w; logic [4:0] r; int lat, low;
        applyStimulus(OPI, 3'd0, 2'b00, 32'd10, 32'd20, 5'd7, 1'b1, d, w, r, lat, low);
        aluop_i = OPR; alufunct3_i = 3'd0; funct7_i = 2'b01;
        reg1_i = 32'd3; reg2_i = 32'd4; wreg_i = 5'd8; wd_i = 1'b1;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        total++; if (ready_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy got=%b req=0", ready_o); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (valid_o !== 1'b0 || wd_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_mid_flags got=%b/%b req=0/0", valid_o, wd_o); end
        total++; if (wreg_o !== 5'd0 || wdata_o !== 32'd0) begin bad++; $display("[TB] FAIL rst_mid_data got=%0d/%h req=0/0", wreg_o, wdata_o); end
        total++; if (ready_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_mid_ready got=%b req=1", ready_o); end
    endtask

    task automatic test_md_disabled();
        int guard = 0;
        while (!ready_o && guard < 100) begin @(posedge clk); #1; guard++; end
        aluop_i = OPR; alufunct3_i = 3'd0; funct7_i = 2'b01;
        reg1_i = 32'd6; reg2_i = 32'd7; wreg_i = 5'd9; wd_i = 1'b1;
        valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        total++; if (d0Valid !== 1'b1 || d0Wd !== 1'b0 || d0Wdata !== 32'd0) begin bad++; $display("[TB] FAIL md_off got=%b/%b/%h req=1/0/0", d0Valid, d0Wd, d0Wdata); end
        total++; if (d0Ready !== 1'b1) begin bad++; $display("[TB] FAIL md_off_ready got=%b req=1", d0Ready); end
        guard = 0;
        while (!valid_o && guard < 100) begin @(posedge clk); #1; guard++; end
        total++; if (wdata_o !== 32'd42 || guard !== 33) begin bad++; $display("[TB] FAIL md_on_mul got=%h/%0d req=2a/33", wdata_o, guard); end
    endtask

    initial begin
        test_reset();
        @(posedge clk); #1;
        test_alu();
        test_mul();
        test_div();
        test_back_to_back();
        test_random();
        test_flush();
        test_rst_mid();
        test_md_disabled();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
